// File: rtl/writeback_unit.sv
// writeback_unit: buffered register-file write-back stage with ALU/load arbitration, load formatting and x0 filtering
// Ports:
//   clk, rst                            clock and asynchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data ALU result handshake (yields to loads)
//   ld_valid/ld_ready/ld_rd/ld_data     load result handshake (fixed priority)
//   ld_funct3, ld_addr_lo               load type and byte offset used for alignment/extension
//   wb_stall                            holds the queue head while high
//   WE3/AD3/WD3                         registered register-file write port
//   busy, count                         queue non-empty flag and occupancy
module writeback_unit #(
    parameter int WIDTH     = 5,
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [WIDTH-1:0]       alu_rd,
    input  logic [DATAWIDTH-1:0]   alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [WIDTH-1:0]       ld_rd,
    input  logic [DATAWIDTH-1:0]   ld_data,
    input  logic [2:0]             ld_funct3,
    input  logic [1:0]             ld_addr_lo,
    input  logic                   wb_stall,
    output logic                   WE3,
    output logic [WIDTH-1:0]       AD3,
    output logic [DATAWIDTH-1:0]   WD3,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0]     q_rd   [DEPTH];
    logic [DATAWIDTH-1:0] q_data [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 full, ld_fire, alu_fire, push, pop;
    logic [WIDTH-1:0]     in_rd;
    logic [DATAWIDTH-1:0] in_data, ld_fmt;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;

    assign full      = count == FULL;
    assign busy      = count != '0;
    assign ld_ready  = !full;
    assign alu_ready = !full && !ld_valid;
    assign ld_fire   = ld_valid && ld_ready;
    assign alu_fire  = alu_valid && alu_ready;
    assign in_rd     = ld_fire ? ld_rd : alu_rd;
    // x0 transfers complete the handshake but never occupy a slot
    assign push      = (ld_fire || alu_fire) && in_rd != '0;
    assign pop       = !wb_stall && busy;
    assign ld_byte   = ld_data[{ld_addr_lo, 3'b000} +: 8];
    assign ld_half   = ld_data[{ld_addr_lo[1], 4'b0000} +: 16];
    assign in_data   = ld_fire ? ld_fmt : alu_data;

    // LW and undefined funct3 values pass the word through unchanged
    always_comb begin
        ld_fmt = ld_funct3 == 3'b000 ? {{(DATAWIDTH-8){ld_byte[7]}}, ld_byte}
               : ld_funct3 == 3'b001 ? {{(DATAWIDTH-16){ld_half[15]}}, ld_half}
               : ld_funct3 == 3'b100 ? {{(DATAWIDTH-8){1'b0}}, ld_byte}
               : ld_funct3 == 3'b101 ? {{(DATAWIDTH-16){1'b0}}, ld_half}
               : ld_data;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= in_rd;
            q_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            WE3    <= 1'b0;
            AD3    <= '0;
            WD3    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            WE3   <= pop;
            if (pop) begin
                AD3 <= q_rd[rd_ptr];
                WD3 <= q_data[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: table-driven and scoreboard bench for writeback_unit
module tb_writeback_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_valid = 1'b0, ld_valid = 1'b0, wb_stall = 1'b0;
    logic [4:0]  alu_rd = '0, ld_rd = '0;
    logic [31:0] alu_data = '0, ld_data = '0, ld_exp_data = '0;
    logic [2:0]  ld_funct3 = '0;
    logic [1:0]  ld_addr_lo = '0;
    logic        alu_ready, ld_ready, WE3, busy;
    logic [4:0]  AD3;
    logic [31:0] WD3;
    logic [2:0]  count;

    writeback_unit dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .ld_funct3(ld_funct3), .ld_addr_lo(ld_addr_lo), .wb_stall(wb_stall),
        .WE3(WE3), .AD3(AD3), .WD3(WD3), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] d);
        logic [31:0] b, h;
        b = d >> (lo * 8);
        h = d >> (lo[1] ? 16 : 0);
        case (f3)
            3'd0: fmt = {{24{b[7]}}, b[7:0]};
            3'd1: fmt = {{16{h[15]}}, h[15:0]};
            3'd4: fmt = {24'd0, b[7:0]};
            3'd5: fmt = {16'd0, h[15:0]};
            default: fmt = d;
        endcase
    endfunction

    // reference model: occupancy, handshake and write scoreboard
    typedef struct packed { logic [4:0] rd; logic [31:0] data; } wr_t;
    wr_t sb[$];
    wr_t item;
    int  m_count = 0;
    logic exp_we = 1'b0, alu_taken = 1'b0, ld_taken = 1'b0;
    logic exp_ld_ready, exp_alu_ready, m_ld_acc, m_alu_acc, m_pop;
    assign exp_ld_ready  = m_count != 4;
    assign exp_alu_ready = m_count != 4 && !ld_valid;
    assign m_ld_acc      = ld_valid && exp_ld_ready;
    assign m_alu_acc     = alu_valid && exp_alu_ready;
    assign m_pop         = !wb_stall && m_count != 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count   <= 0;
            exp_we    <= 1'b0;
            alu_taken <= 1'b0;
            ld_taken  <= 1'b0;
            sb.delete();
        end else begin
            if (m_ld_acc && ld_rd != 0) sb.push_back({ld_rd, ld_exp_data});
            else if (m_alu_acc && alu_rd != 0) sb.push_back({alu_rd, alu_data});
            m_count   <= m_count + ((m_ld_acc && ld_rd != 0) || (m_alu_acc && alu_rd != 0) ? 1 : 0) - (m_pop ? 1 : 0);
            exp_we    <= m_pop;
            alu_taken <= m_alu_acc;
            ld_taken  <= m_ld_acc;
        end
    end

    always begin
        @(negedge clk);
        #1;
        chk("ld_ready", 32'(ld_ready), 32'(exp_ld_ready));
        chk("alu_ready", 32'(alu_ready), 32'(exp_alu_ready));
        chk("count", 32'(count), 32'(m_count));
        chk("busy", 32'(busy), 32'(m_count != 0));
        chk("WE3", 32'(WE3), 32'(exp_we));
        if (exp_we) begin
            if (sb.size() == 0) chk("scoreboard_empty", 32'(sb.size()), 32'd1);
            else begin
                item = sb.pop_front();
                chk("AD3", 32'(AD3), 32'(item.rd));
                chk("WD3", WD3, item.data);
            end
        end
    end

    task automatic wait_alu();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (alu_taken) begin
                alu_valid = 1'b0;
                return;
            end
        end
        chk("alu_timeout", 32'd0, 32'd1);
        alu_valid = 1'b0;
    endtask

    task automatic send_alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_rd    = rd;
        alu_data  = d;
        wait_alu();
    endtask

    task automatic send_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] d, input logic [31:0] exp);
        ld_valid = 1'b1; ld_rd = rd; ld_funct3 = f3; ld_addr_lo = lo; ld_data = d; ld_exp_data = exp;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ld_taken) begin
                ld_valid = 1'b0;
                return;
            end
        end
        chk("ld_timeout", 32'd0, 32'd1);
        ld_valid = 1'b0;
    endtask

    typedef struct { logic [2:0] f3; logic [1:0] lo; logic [4:0] rd; logic [31:0] exp; } ldvec_t;
    ldvec_t lv[10];

    initial begin
        lv[0] = '{3'd0, 2'd0, 5'd1,  32'h0000_007F};
        lv[1] = '{3'd0, 2'd1, 5'd2,  32'hFFFF_FFF2};
        lv[2] = '{3'd4, 2'd3, 5'd3,  32'h0000_0080};
        lv[3] = '{3'd1, 2'd2, 5'd6,  32'hFFFF_8081};
        lv[4] = '{3'd5, 2'd0, 5'd7,  32'h0000_F27F};
        lv[5] = '{3'd2, 2'd0, 5'd8,  32'h8081_F27F};
        lv[6] = '{3'd0, 2'd3, 5'd9,  32'hFFFF_FF80};
        lv[7] = '{3'd4, 2'd1, 5'd10, 32'h0000_00F2};
        lv[8] = '{3'd5, 2'd2, 5'd11, 32'h0000_8081};
        lv[9] = '{3'd3, 2'd1, 5'd12, 32'h8081_F27F};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_WE3", 32'(WE3), 32'd0);
        chk("rst_AD3", 32'(AD3), 32'd0);
        chk("rst_WD3", WD3, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // single ALU write: visible one full cycle after acceptance, for exactly one cycle
        send_alu(5'd5, 32'h0000_00AA);
        @(negedge clk); #2;
        chk("t1_WE3", 32'(WE3), 32'd1);
        chk("t1_AD3", 32'(AD3), 32'd5);
        chk("t1_WD3", WD3, 32'h0000_00AA);
        @(negedge clk); #2;
        chk("t1_WE3_off", 32'(WE3), 32'd0);
        chk("t1_count", 32'(count), 32'd0);

        foreach (lv[i]) send_ld(lv[i].rd, lv[i].f3, lv[i].lo, 32'h8081_F27F, lv[i].exp);
        repeat (3) @(negedge clk);

        // arbitration: load wins, ALU follows next cycle
        ld_valid = 1'b1; ld_rd = 5'd3; ld_funct3 = 3'd2; ld_addr_lo = 2'd0;
        ld_data = 32'h1234_5678; ld_exp_data = 32'h1234_5678;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hCAFE_0004;
        #1;
        chk("arb_ld_ready", 32'(ld_ready), 32'd1);
        chk("arb_alu_ready", 32'(alu_ready), 32'd0);
        @(negedge clk);
        ld_valid = 1'b0;
        wait_alu();
        repeat (3) @(negedge clk);

        // full under stall, then drain with wrap
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) send_alu(5'(16 + i), 32'hA000_0000 + i);
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'hA000_0004;
        #1;
        chk("full_count", 32'(count), 32'd4);
        chk("full_alu_ready", 32'(alu_ready), 32'd0);
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("full_hold_count", 32'(count), 32'd4);
        wb_stall = 1'b0;
        wait_alu();
        repeat (6) @(negedge clk);

        // x0 drop
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
        #1;
        chk("x0_alu_ready", 32'(alu_ready), 32'd1);
        wait_alu();
        #1;
        chk("x0_count", 32'(count), 32'd0);
        repeat (3) @(negedge clk);

        // sustained throughput
        for (int i = 0; i < 8; i++) send_alu(5'(1 + i), $urandom);
        repeat (4) @(negedge clk);

        // random mix with stalls; held ALU offers stay stable until taken
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (!alu_valid || alu_taken) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd    = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            ld_valid    = $urandom_range(0, 2) == 0;
            ld_rd       = 5'($urandom_range(0, 31));
            ld_funct3   = 3'($urandom_range(0, 7));
            ld_addr_lo  = 2'($urandom_range(0, 3));
            ld_data     = $urandom;
            ld_exp_data = fmt(ld_funct3, ld_addr_lo, ld_data);
            wb_stall    = $urandom_range(0, 3) == 0;
        end
        @(negedge clk);
        alu_valid = 1'b0; ld_valid = 1'b0; wb_stall = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("drain_count", 32'(count), 32'd0);

        // mid-operation reset with a write in flight
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) send_alu(5'(20 + i), 32'hB000_0000 + i);
        wb_stall = 1'b0;
        @(posedge clk); #2;
        chk("mr_inflight", 32'(WE3), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_WE3", 32'(WE3), 32'd0);
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
